// File: rtl/gpi_pkg.sv
// Shared types, limits and parameter sanity check for the GPI input conditioner.
package gpi_pkg;

  // Per-channel debounce state: STABLE while gpi_db matches the pin,
  // QUALIFY while a differing level is being timed.
  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } db_state_t;

  localparam int GPI_SYNC_MIN = 2;
  localparam int GPI_SYNC_MAX = 4;

  // True when the parameter set is usable: at least two qualification
  // cycles and a synchroniser depth inside the supported range.
  function automatic bit gpi_params_ok(input int sync_stages, input int debounce_cycles);
    return (debounce_cycles >= 2) &&
           (sync_stages >= GPI_SYNC_MIN) &&
           (sync_stages <= GPI_SYNC_MAX);
  endfunction

endpackage

// File: rtl/gpi_debounce_ch.sv
// One GPI channel: pin synchroniser, qualification counter FSM, registered
// rise/fall pulses and a sticky event flag with a per-channel clear.
module gpi_debounce_ch
  import gpi_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 480000,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic gpi_raw,
  input  logic evt_clr,
  output logic gpi_db,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic evt_pending
);

  // Wide enough to hold DEBOUNCE_CYCLES; the count never passes DEBOUNCE_CYCLES-1.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_lvl;
  db_state_t              state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   gpi_db_reg;
  logic                   rise_reg;
  logic                   fall_reg;
  logic                   pend_reg;

  // Shift the asynchronous pin through the synchroniser chain; the last
  // stage is the only view of the pin the rest of the channel ever sees.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_reg <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], gpi_raw};
    end
  end

  assign sync_lvl = sync_reg[SYNC_STAGES-1];

  // Qualification FSM with registered level, edge pulses and sticky flag.
  // The flag's set is written after its clear so that a set on the same
  // edge as a clear leaves the flag high.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= STABLE;
      cnt_reg    <= '0;
      gpi_db_reg <= RESET_LEVEL;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
      pend_reg   <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      pend_reg <= pend_reg & ~evt_clr;
      case (state_reg)
        STABLE: begin
          if (sync_lvl != gpi_db_reg) begin
            state_reg <= QUALIFY;
            cnt_reg   <= CNT_ONE;
          end
        end
        QUALIFY: begin
          if (sync_lvl == gpi_db_reg) begin
            // Pin fell back before qualifying: discard the attempt.
            state_reg <= STABLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            gpi_db_reg <= sync_lvl;
            rise_reg   <= sync_lvl;
            fall_reg   <= ~sync_lvl;
            pend_reg   <= 1'b1;
            state_reg  <= STABLE;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        default: begin
          state_reg <= STABLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign gpi_db      = gpi_db_reg;
  assign rise_pulse  = rise_reg;
  assign fall_pulse  = fall_reg;
  assign evt_pending = pend_reg;

endmodule

// File: rtl/gpi_debounce.sv
// GPI input conditioner: N_CH fully independent debounce channels sitting
// between the board pins and the core's io_gpi_* inputs.
module gpi_debounce
  import gpi_pkg::*;
#(
  parameter int   N_CH            = 1,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 480000,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] gpi_raw,
  output logic [N_CH-1:0] gpi_db,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] evt_pending,
  input  logic [N_CH-1:0] evt_clr
);

  // Refuse to elaborate with a synchroniser depth or debounce length the
  // channel logic was not built for.
  if (!gpi_params_ok(SYNC_STAGES, DEBOUNCE_CYCLES)) begin : g_param_err
    $error("gpi_debounce: SYNC_STAGES must be 2..4 and DEBOUNCE_CYCLES >= 2");
  end

  // One self-contained channel per input pin; nothing is shared between them.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    gpi_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .gpi_raw    (gpi_raw[gi]),
      .evt_clr    (evt_clr[gi]),
      .gpi_db     (gpi_db[gi]),
      .rise_pulse (rise_pulse[gi]),
      .fall_pulse (fall_pulse[gi]),
      .evt_pending(evt_pending[gi])
    );
  end

endmodule

// File: tb/tb_gpi_debounce.sv
// Scoreboarded bench for gpi_debounce (2 channels, 2 sync stages, 4-cycle
// debounce). Stimulus pushes the expected pulse events, stamped with the
// clock edge on which they must appear; a monitor pops and compares them
// whenever the DUT shows a rise or fall pulse.
module tb_gpi_debounce;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] gpi_raw;
  logic [1:0] evt_clr;
  logic [1:0] gpi_db;
  logic [1:0] rise_pulse;
  logic [1:0] fall_pulse;
  logic [1:0] evt_pending;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    string      name;
    int         cyc;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] db;
    logic [1:0] pend;
  } exp_t;

  exp_t exp_q[$];

  gpi_debounce #(
    .N_CH           (2),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .RESET_LEVEL    (1'b0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .gpi_raw    (gpi_raw),
    .gpi_db     (gpi_db),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .evt_pending(evt_pending),
    .evt_clr    (evt_clr)
  );

  always #5 clock = ~clock;

  // Count rising edges; cyc == k between edge k and edge k+1.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check2(input string name, input logic [1:0] act, input logic [1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic checki(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Expect a pulse event 'delta' edges after the current edge count.
  task automatic push_exp(input string name, input int delta, input logic [1:0] rise,
                          input logic [1:0] fall, input logic [1:0] db, input logic [1:0] pend);
    exp_t e;
    e.name = name;
    e.cyc  = cyc + delta;
    e.rise = rise;
    e.fall = fall;
    e.db   = db;
    e.pend = pend;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One-cycle clear strobe, then check the resulting flags.
  task automatic clear_and_check(input string name, input logic [1:0] mask, input logic [1:0] req);
    evt_clr = mask;
    step(1);
    evt_clr = 2'b00;
    check2(name, evt_pending, req);
  endtask

  // Monitor: every visible pulse must match the next expected event.
  always @(negedge clock) begin
    if ((rise_pulse | fall_pulse) != 2'b00) begin
      if (exp_q.size() == 0) begin
        check2("unexpected_pulse", rise_pulse | fall_pulse, 2'b00);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("[TB] %s edge=%0d rise=%b fall=%b db=%b pend=%b",
                 e.name, cyc, rise_pulse, fall_pulse, gpi_db, evt_pending);
        checki({e.name, "_edge"}, cyc, e.cyc);
        check2({e.name, "_rise"}, rise_pulse, e.rise);
        check2({e.name, "_fall"}, fall_pulse, e.fall);
        check2({e.name, "_db"},   gpi_db,     e.db);
        check2({e.name, "_pend"}, evt_pending, e.pend);
      end
    end
  end

  initial begin
    bit bounce [6];
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    reset   = 1'b1;
    gpi_raw = 2'b11;
    evt_clr = 2'b00;
    step(3);
    check2("reset_db",   gpi_db,      2'b00);
    check2("reset_rise", rise_pulse,  2'b00);
    check2("reset_fall", fall_pulse,  2'b00);
    check2("reset_pend", evt_pending, 2'b00);

    // Pins already high at release: both rise on edge 6 after release.
    reset = 1'b0;
    push_exp("release_rise", 6, 2'b11, 2'b00, 2'b11, 2'b11);
    step(10);

    // Clear only channel 0; channel 1 must keep its flag.
    clear_and_check("clr_ch0", 2'b01, 2'b10);
    clear_and_check("clr_idle", 2'b01, 2'b10);

    gpi_raw = 2'b00;
    push_exp("fall_both", 6, 2'b00, 2'b11, 2'b00, 2'b11);
    step(10);
    clear_and_check("clr_both", 2'b11, 2'b00);

    // Clean edges on channel 0.
    gpi_raw = 2'b01;
    push_exp("clean_rise", 6, 2'b01, 2'b00, 2'b01, 2'b01);
    step(10);
    gpi_raw = 2'b00;
    push_exp("clean_fall", 6, 2'b00, 2'b01, 2'b00, 2'b01);
    step(10);
    clear_and_check("clr_clean", 2'b01, 2'b00);

    // Three cycles high is one short of qualifying.
    gpi_raw = 2'b01;
    step(3);
    gpi_raw = 2'b00;
    step(10);
    check2("glitch_db",   gpi_db,      2'b00);
    check2("glitch_pend", evt_pending, 2'b00);

    // Four cycles high just qualifies; the fall follows DEBOUNCE_CYCLES later.
    gpi_raw = 2'b01;
    push_exp("min_rise", 6,  2'b01, 2'b00, 2'b01, 2'b01);
    push_exp("min_fall", 10, 2'b00, 2'b01, 2'b00, 2'b01);
    step(4);
    gpi_raw = 2'b00;
    step(12);
    clear_and_check("clr_min", 2'b01, 2'b00);

    // Bounce train; the final 0->1 is driven 5 cycles after the first.
    push_exp("bounce_rise", 11, 2'b01, 2'b00, 2'b01, 2'b01);
    for (int i = 0; i < 6; i++) begin
      gpi_raw[0] = bounce[i];
      step(1);
    end
    step(10);
    gpi_raw = 2'b00;
    push_exp("bounce_fall", 6, 2'b00, 2'b01, 2'b00, 2'b01);
    step(10);
    clear_and_check("clr_bounce", 2'b01, 2'b00);

    // Clear sampled on the very edge that raises rise_pulse: set wins.
    gpi_raw = 2'b01;
    push_exp("setwin_rise", 6, 2'b01, 2'b00, 2'b01, 2'b01);
    step(5);
    evt_clr = 2'b01;
    step(1);
    evt_clr = 2'b00;
    step(1);
    check2("setwin_hold", evt_pending, 2'b01);
    clear_and_check("clr_setwin", 2'b01, 2'b00);
    gpi_raw = 2'b00;
    push_exp("setwin_fall", 6, 2'b00, 2'b01, 2'b00, 2'b01);
    step(10);
    clear_and_check("clr_final", 2'b01, 2'b00);

    // Reset in the middle of qualifying channel 1 abandons the change.
    gpi_raw = 2'b10;
    step(3);
    reset   = 1'b1;
    gpi_raw = 2'b00;
    step(2);
    check2("rst_mid_db", gpi_db, 2'b00);
    reset = 1'b0;
    step(12);
    check2("rst_after_db",   gpi_db,      2'b00);
    check2("rst_after_pend", evt_pending, 2'b00);

    checki("events_outstanding", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpi_debounce.md
Name: gpi_debounce

Overview:
- Input conditioner that sits directly upstream of the SoC core's general-purpose input pins (io_gpi_*), between the board pins (user button, header inputs) and the core.
- Per channel: synchronises the asynchronous pin, debounces it with a qualification counter, and produces a clean level.
- Also produces one-cycle rise/fall event pulses and a sticky event flag with a clear handshake, so firmware polling GPI cannot miss a press.

Parameters:
- N_CH, 1, number of input channels.
- SYNC_STAGES, 2, synchroniser depth; legal range 2..4.
- DEBOUNCE_CYCLES, 480000, consecutive cycles a new level must persist before it is accepted. Default is 10 ms at 48 MHz. Must be >= 2.
- RESET_LEVEL, 1'b0, value loaded into synchroniser flops and gpi_db at reset; same for all channels.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width; derived, do not override.

Ports:
- clock  input  1  system clock (PLL output domain).
- reset  input  1  synchronous, active-high reset.
- gpi_raw  input  N_CH  asynchronous pin levels.
- gpi_db  output  N_CH  debounced level; feeds the core's io_gpi_*.
- rise_pulse  output  N_CH  one-cycle pulse when gpi_db goes 0->1.
- fall_pulse  output  N_CH  one-cycle pulse when gpi_db goes 1->0.
- evt_pending  output  N_CH  sticky flag, set on any accepted edge.
- evt_clr  input  N_CH  per-channel clear of evt_pending; one-cycle strobe or held level.

Behaviour:
- Reset: synchroniser flops = RESET_LEVEL, gpi_db = RESET_LEVEL, counters = 0, FSM = STABLE, rise/fall_pulse = 0, evt_pending = 0.
- No edge is generated on reset release.
- Reset asserted mid-qualification abandons the pending change; no pulse is generated.
- Synchroniser: SYNC_STAGES flops per channel. sync = last stage. There is no other path from gpi_raw.
- Per-channel FSM, two states:
  - STABLE (cnt = 0): if sync != gpi_db, go to QUALIFY with cnt = 1. Otherwise stay in STABLE.
  - QUALIFY: if sync == gpi_db (glitch), go to STABLE with cnt = 0 and no output change.
  - QUALIFY: else if cnt == DEBOUNCE_CYCLES-1, flip gpi_db, pulse, go to STABLE with cnt = 0.
  - QUALIFY: else cnt = cnt + 1.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Latency: raw level held constant from the first edge that samples it. gpi_db updates on rising edge number SYNC_STAGES + DEBOUNCE_CYCLES, counting that first edge as 1.
- Pulses:
  - rise_pulse/fall_pulse are registered, high exactly in the cycle where the new gpi_db is first visible, for one cycle.
  - Never both high on one channel.
  - Minimum spacing between accepted edges is DEBOUNCE_CYCLES cycles.
- evt_pending:
  - Set on the edge that raises either pulse.
  - Cleared on the edge after evt_clr is sampled high.
  - Simultaneous set and clear: set wins, so the flag stays 1.
  - evt_clr while the flag is already 0: no effect.
- Channels are fully independent; no shared counter.
- All outputs are registered; no combinational path from any input to any output.

Decomposition:
- Package gpi_pkg:
  - enum db_state_t {STABLE, QUALIFY}.
  - constant GPI_SYNC_MIN = 2.
  - elaboration-time check function asserting DEBOUNCE_CYCLES >= 2 and SYNC_STAGES within 2..4.
- Sub-module gpi_debounce_ch:
  - Contains one channel's synchroniser, FSM/counter, pulse and sticky flag.
  - Parameters SYNC_STAGES, DEBOUNCE_CYCLES, RESET_LEVEL.
  - The top replicates it N_CH times in a generate loop.
- Integration: the system top instantiates gpi_debounce on usr_btn_i and drives the core's io_gpi_0 from gpi_db[0].

Test Plan (bench uses N_CH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0):
- Reset with gpi_raw=2'b11 held through reset, then release -> gpi_db=00, no pulses, evt_pending=00 during reset. After release, rise_pulse[1:0]=11 on edge 6 counted from the first post-reset edge (SYNC_STAGES+DEBOUNCE_CYCLES=6), evt_pending=11.
- Clean edge: gpi_raw[0] 0->1 and held -> gpi_db[0]=1 and rise_pulse[0]=1 on the 6th edge, pulse lasts exactly 1 cycle. Then 1->0 -> fall_pulse[0] on the 6th edge.
- Glitch: gpi_raw[0] high for 3 cycles then low -> gpi_db[0] stays 0, no pulse, evt_pending[0]=0, counter returns to 0.
- Bounce train: raw toggles 1,0,1,1,0,1 then holds 1 -> exactly one rise_pulse[0], 6 edges after the final 0->1.
- Sticky handshake:
  - evt_clr[0] pulse -> evt_pending[0]=0 the next cycle.
  - evt_clr[0] asserted in the same cycle as a new rise_pulse[0] -> evt_pending[0] stays 1.
  - Channel 1 unaffected throughout.
- Reset mid-qualify: raise gpi_raw[1], assert reset after 3 edges, release with raw=0 -> no pulse ever, gpi_db[1]=0.
